// File: rtl/button_conditioner.sv
// button_conditioner
//
// Input stage between raw board push-buttons and the Player core.
// Each button goes through three stages:
//   1. A two-flop synchroniser.
//   2. A debouncer. It only accepts a new level once the synchronised
//      input has held that level for DEBOUNCE_CYCLES consecutive cycles.
//   3. A one-cycle press or release pulse, raised when a new level is
//      accepted.
// The block also generates player_reset. It stays high while the
// designated reset button is held. It then stays high for RESET_STRETCH
// more cycles after that button is released, or after local reset.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset for this block
//   btn          raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle pulse when a press is accepted
//   btn_release  one-cycle pulse when a release is accepted
//   player_reset synchronous active-high reset for the downstream player
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int RESET_BTN       = 0,
    parameter int RESET_STRETCH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               player_reset
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int STR_W = $clog2(RESET_STRETCH + 1);

    // Pin level of a button that is not pressed.
    localparam logic [NUM_BTN-1:0] IDLE_PINS = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0]   STR_LOAD  = STR_W'(RESET_STRETCH);

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] raw_pressed;

    logic [CNT_W-1:0]   cnt     [NUM_BTN];
    logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] level_nxt;
    logic [NUM_BTN-1:0] press_nxt;
    logic [NUM_BTN-1:0] release_nxt;

    logic [STR_W-1:0]   stretch;

    // Synchroniser. It resets to the idle pin level so that reset itself
    // never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_PINS;
            sync2 <= IDLE_PINS;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign raw_pressed = sync2 ^ IDLE_PINS;

    // Debounce decision for each button. Any cycle where the input agrees
    // with the accepted level clears the count, so a bounce gives no
    // partial credit.
    always_comb begin
        level_nxt   = btn_level;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (raw_pressed[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_nxt[i]   = raw_pressed[i];
                    press_nxt[i]   = raw_pressed[i];
                    release_nxt[i] = ~raw_pressed[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Stretch counter. It loads on the same edge that raises the release
    // pulse. player_reset reads the old btn_level on that edge, so the
    // hand-over from "button held" to "stretch running" leaves no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stretch <= STR_LOAD;
        end else if (release_nxt[RESET_BTN]) begin
            stretch <= STR_LOAD;
        end else if (stretch != '0) begin
            stretch <= stretch - STR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            player_reset <= 1'b1;
        end else begin
            player_reset <= btn_level[RESET_BTN] | (stretch != '0);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner.
//
// A reference model runs on every clock edge. It pushes the outputs it
// expects into a queue, and a separate monitor pops them on the falling
// edge and compares them with the DUT.
//
// The model describes behaviour rather than structure:
//   - A button's level flips once its synchronised input has disagreed
//     with the level for DEBOUNCE consecutive edges.
//   - player_reset is computed from the button level and from how many
//     edges have passed since the last release or the last local reset.
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int DB  = 8;
    localparam int RS  = 4;
    localparam int RB  = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn = '1;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          player_reset;

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW(1),
        .RESET_BTN(RB),
        .RESET_STRETCH(RS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .player_reset(player_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic          pr;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [NB-1:0] m_seen1 = '0;   // pressed-ness sampled at the last edge
    logic [NB-1:0] m_seen2 = '0;   // ... and the edge before that
    logic [NB-1:0] m_lvl   = '0;
    int            m_run [NB];
    int            m_edge     = 0;
    int            m_last_rel = -1000;
    int            m_last_rst = -1000;
    int            m_press_cnt = 0;

    always @(posedge clk) begin
        exp_t          e;
        logic [NB-1:0] seen;
        logic          lvl_before;
        m_edge++;
        e = '0;
        if (reset) begin
            m_lvl   = '0;
            m_seen1 = '0;
            m_seen2 = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_last_rst = m_edge;
            e.pr = 1'b1;
        end else begin
            seen       = m_seen2;
            lvl_before = m_lvl[RB];
            for (int i = 0; i < NB; i++) begin
                if (seen[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = seen[i];
                        m_run[i] = 0;
                        if (seen[i]) begin
                            e.prs[i] = 1'b1;
                            m_press_cnt++;
                        end else begin
                            e.rel[i] = 1'b1;
                        end
                    end
                end
            end
            if (e.rel[RB]) m_last_rel = m_edge;
            e.pr = lvl_before
                || ((m_edge - m_last_rel) >= 1 && (m_edge - m_last_rel) <= RS)
                || ((m_edge - m_last_rst) >= 1 && (m_edge - m_last_rst) <= RS);
            m_seen2 = m_seen1;
            m_seen1 = ~btn;
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compares every registered output once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("btn_level",    btn_level,   e.lvl);
            chk("btn_press",    btn_press,   e.prs);
            chk("btn_release",  btn_release, e.rel);
            chk("player_reset", {3'b000, player_reset}, {3'b000, e.pr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Power-on reset.
        reset = 1'b1;
        btn   = 4'hF;
        cyc(3);
        reset = 1'b0;
        cyc(10);

        // Clean press and release on btn[2].
        btn[2] = 1'b0; cyc(15);
        btn[2] = 1'b1; cyc(15);

        // Bouncing press on btn[1].
        btn[1] = 1'b0; cyc(7);
        btn[1] = 1'b1; cyc(1);
        btn[1] = 1'b0; cyc(20);
        btn[1] = 1'b1; cyc(15);

        // Reset button, with a re-press during the stretch.
        btn[0] = 1'b0; cyc(30);
        btn[0] = 1'b1; cyc(12);
        btn[0] = 1'b0; cyc(5);
        btn[0] = 1'b1; cyc(25);

        // Simultaneous presses on btn[3] and btn[1].
        btn[3] = 1'b0; btn[1] = 1'b0; cyc(15);
        btn[3] = 1'b1; btn[1] = 1'b1; cyc(15);

        // Local reset in the middle of a debounce on btn[2].
        btn[2] = 1'b0; cyc(7);
        reset = 1'b1;  cyc(2);
        reset = 1'b0;  cyc(20);
        btn[2] = 1'b1; cyc(15);

        // Random toggling: a mix of glitches, accepted changes and
        // occasional local resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            end
            reset = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        reset = 1'b0;
        btn   = 4'hF;
        cyc(30);

        // The model must have seen presses, and the queue must be drained.
        checks++;
        if (m_press_cnt < 5) begin
            errors++;
            $display("FAIL press_activity: got %0d model presses, expected at least 5", m_press_cnt);
        end
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, expected at most 1", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
